// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: opcodes, funct3 codes, the inter-stage packet and
// the memory-stage FSM/format encodings.
package rv32i_types;

    typedef enum logic [6:0] {
        OpLui   = 7'b0110111,
        OpAuipc = 7'b0010111,
        OpJal   = 7'b1101111,
        OpJalr  = 7'b1100111,
        OpBr    = 7'b1100011,
        OpLoad  = 7'b0000011,
        OpStore = 7'b0100011,
        OpImm   = 7'b0010011,
        OpReg   = 7'b0110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        Lb  = 3'b000,
        Lh  = 3'b001,
        Lw  = 3'b010,
        Lbu = 3'b100,
        Lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        Sb = 3'b000,
        Sh = 3'b001,
        Sw = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {StIdle, StWait, StDone} mem_state_t;

    typedef enum logic [2:0] {FmtB, FmtBu, FmtH, FmtHu, FmtW} mem_fmt_t;

    typedef struct packed {
        logic       valid;
        logic [6:0] opcode;
        logic [2:0] funct3;
    } rv32i_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] rs2_out;
        logic [31:0] mem_rdata;
    } rv32i_data_t;

    typedef struct packed {
        rv32i_ctrl_t ctrl;
        rv32i_data_t data;
    } rv32i_packet_t;

    // Store funct3 codes share the low two bits with the load codes.
    function automatic mem_fmt_t fmt_of(input logic [2:0] funct3);
        case (funct3)
            Lb:      return FmtB;
            Lbu:     return FmtBu;
            Lh:      return FmtH;
            Lhu:     return FmtHu;
            default: return FmtW;
        endcase
    endfunction

    function automatic logic misaligned(input mem_fmt_t fmt, input logic [1:0] offset);
        case (fmt)
            FmtH, FmtHu: return offset[0];
            FmtW:        return offset != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store byte enables / replicated store data, and
// load byte/half/word extraction with sign or zero extension.
module mem_align
    import rv32i_types::*;
(
    input  mem_fmt_t    fmt_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_word_i,
    output logic [3:0]  store_mbe_o,
    output logic [31:0] store_wdata_o,
    output logic [31:0] load_data_o
);

    logic [31:0] shifted;

    assign shifted = load_word_i >> {offset_i, 3'b000};

    always_comb begin
        store_mbe_o   = 4'b1111;
        store_wdata_o = store_data_i;
        load_data_o   = shifted;
        case (fmt_i)
            FmtB: begin
                store_mbe_o   = 4'b0001 << offset_i;
                store_wdata_o = {4{store_data_i[7:0]}};
                load_data_o   = {{24{shifted[7]}}, shifted[7:0]};
            end
            FmtBu: begin
                store_mbe_o   = 4'b0001 << offset_i;
                store_wdata_o = {4{store_data_i[7:0]}};
                load_data_o   = {24'h0, shifted[7:0]};
            end
            FmtH: begin
                store_mbe_o   = 4'b0011 << offset_i;
                store_wdata_o = {2{store_data_i[15:0]}};
                load_data_o   = {{16{shifted[15]}}, shifted[15:0]};
            end
            FmtHu: begin
                store_mbe_o   = 4'b0011 << offset_i;
                store_wdata_o = {2{store_data_i[15:0]}};
                load_data_o   = {16'h0, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: EX/MEM register, data-memory handshake FSM and load formatting.
// Optional MEM_MISALIGN_TRAP_EN suppresses misaligned accesses and flags them.
module mem_stage
    import rv32i_types::*;
(
    input  logic          clk,
    input  logic          rst,
    input  rv32i_packet_t packet_in,
    input  logic          stall_in,
    output logic          dmem_read,
    output logic          dmem_write,
    output logic [31:0]   dmem_address,
    output logic [3:0]    dmem_mbe,
    output logic [31:0]   dmem_wdata,
    input  logic [31:0]   dmem_rdata,
    input  logic          dmem_resp,
    output logic [31:0]   from_exmem,
    output logic          stall_out,
    output logic          misalign,
    output rv32i_packet_t packet_out
);

    rv32i_packet_t exmem_q;
    mem_state_t    state_q;
    logic [31:0]   rdata_buf_q;

    logic        is_load, is_store, mem_op, req, resp_ok;
    logic [1:0]  offset;
    mem_fmt_t    fmt;
    logic [3:0]  store_mbe;
    logic [31:0] store_wdata, load_src, load_data;

    assign is_load  = exmem_q.ctrl.valid && (exmem_q.ctrl.opcode == OpLoad);
    assign is_store = exmem_q.ctrl.valid && (exmem_q.ctrl.opcode == OpStore);
    assign offset   = exmem_q.data.alu_out[1:0];
    assign fmt      = fmt_of(exmem_q.ctrl.funct3);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = (is_load || is_store) && misaligned(fmt, offset);
`else
    assign misalign = 1'b0;
`endif

    assign mem_op    = (is_load || is_store) && !misalign;
    assign req       = mem_op && (state_q != StDone);
    // Responses are only meaningful while a request is actually on the port.
    assign resp_ok   = dmem_resp && req;
    assign stall_out = req && !dmem_resp;

    assign dmem_read    = req && is_load;
    assign dmem_write   = req && is_store;
    assign dmem_address = {exmem_q.data.alu_out[31:2], 2'b00};
    assign dmem_mbe     = dmem_read ? 4'b1111 : (dmem_write ? store_mbe : 4'b0000);
    assign dmem_wdata   = dmem_write ? store_wdata : 32'h0;
    assign from_exmem   = exmem_q.data.alu_out;

    assign load_src = (state_q == StDone) ? rdata_buf_q : dmem_rdata;

    mem_align u_mem_align (
        .fmt_i        (fmt),
        .offset_i     (offset),
        .store_data_i (exmem_q.data.rs2_out),
        .load_word_i  (load_src),
        .store_mbe_o  (store_mbe),
        .store_wdata_o(store_wdata),
        .load_data_o  (load_data)
    );

    always_comb begin
        packet_out                = exmem_q;
        packet_out.ctrl.valid     = exmem_q.ctrl.valid && !misalign;
        packet_out.data.mem_rdata = is_load ? load_data : 32'h0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exmem_q     <= '0;
            rdata_buf_q <= 32'h0;
        end else begin
            if (!stall_in && !stall_out) exmem_q <= packet_in;
            if (resp_ok) rdata_buf_q <= dmem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (mem_op) begin
                        if (!dmem_resp) state_q <= StWait;
                        else if (stall_in) state_q <= StDone;
                    end
                end
                StWait:  if (dmem_resp) state_q <= stall_in ? StDone : StIdle;
                StDone:  if (!stall_in) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: reset, stores, waited and held loads,
// mid-access reset, non-memory ops and misaligned word access.
module tb_mem_stage;
    import rv32i_types::*;

    logic          clk;
    logic          rst;
    rv32i_packet_t packet_in;
    logic          stall_in;
    logic          dmem_read, dmem_write;
    logic [31:0]   dmem_address;
    logic [3:0]    dmem_mbe;
    logic [31:0]   dmem_wdata;
    logic [31:0]   dmem_rdata;
    logic          dmem_resp;
    logic [31:0]   from_exmem;
    logic          stall_out;
    logic          misalign;
    rv32i_packet_t packet_out;

    int vectors = 0;
    int miscompares = 0;

    mem_stage dut (
        .clk         (clk),
        .rst         (rst),
        .packet_in   (packet_in),
        .stall_in    (stall_in),
        .dmem_read   (dmem_read),
        .dmem_write  (dmem_write),
        .dmem_address(dmem_address),
        .dmem_mbe    (dmem_mbe),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_resp   (dmem_resp),
        .from_exmem  (from_exmem),
        .stall_out   (stall_out),
        .misalign    (misalign),
        .packet_out  (packet_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic rv32i_packet_t mk(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [31:0] alu, input logic [31:0] rs2);
        rv32i_packet_t p;
        p = '0;
        p.ctrl.valid    = 1'b1;
        p.ctrl.opcode   = op;
        p.ctrl.funct3   = f3;
        p.data.alu_out  = alu;
        p.data.rs2_out  = rs2;
        return p;
    endfunction

    // Called at a negedge; returns at the next negedge with p held in EX/MEM.
    task automatic issue(input rv32i_packet_t p);
        packet_in = p;
        @(posedge clk);
        #1 packet_in = '0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #2;
        vectors++; if (dmem_read !== 1'b0) begin miscompares++; $display("FAIL rst_read: got %b want 0", dmem_read); end
        vectors++; if (dmem_write !== 1'b0) begin miscompares++; $display("FAIL rst_write: got %b want 0", dmem_write); end
        vectors++; if (dmem_mbe !== 4'b0000) begin miscompares++; $display("FAIL rst_mbe: got %b want 0000", dmem_mbe); end
        vectors++; if (stall_out !== 1'b0) begin miscompares++; $display("FAIL rst_stall: got %b want 0", stall_out); end
        vectors++; if (misalign !== 1'b0) begin miscompares++; $display("FAIL rst_misalign: got %b want 0", misalign); end
        vectors++; if (from_exmem !== 32'h0) begin miscompares++; $display("FAIL rst_fwd: got %h want 0", from_exmem); end
        vectors++; if (packet_out !== '0) begin miscompares++; $display("FAIL rst_packet: got %h want 0", packet_out); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sw_zero_wait;
        issue(mk(OpStore, Sw, 32'h100, 32'hDEADBEEF));
        dmem_resp = 1'b1;
        #1;
        vectors++; if (dmem_write !== 1'b1) begin miscompares++; $display("FAIL sw_write: got %b want 1", dmem_write); end
        vectors++; if (dmem_address !== 32'h100) begin miscompares++; $display("FAIL sw_addr: got %h want 00000100", dmem_address); end
        vectors++; if (dmem_mbe !== 4'b1111) begin miscompares++; $display("FAIL sw_mbe: got %b want 1111", dmem_mbe); end
        vectors++; if (dmem_wdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sw_wdata: got %h want deadbeef", dmem_wdata); end
        vectors++; if (stall_out !== 1'b0) begin miscompares++; $display("FAIL sw_stall: got %b want 0", stall_out); end
        @(negedge clk);
        dmem_resp = 1'b0;
        #1;
        vectors++; if (dmem_write !== 1'b0 || stall_out !== 1'b0) begin miscompares++; $display("FAIL sw_retired: got write=%b stall=%b want 0 0", dmem_write, stall_out); end
    endtask

    task automatic test_sb;
        issue(mk(OpStore, Sb, 32'h203, 32'h0000005A));
        dmem_resp = 1'b1;
        #1;
        vectors++; if (dmem_mbe !== 4'b1000) begin miscompares++; $display("FAIL sb_mbe: got %b want 1000", dmem_mbe); end
        vectors++; if (dmem_wdata !== 32'h5A5A5A5A) begin miscompares++; $display("FAIL sb_wdata: got %h want 5a5a5a5a", dmem_wdata); end
        vectors++; if (dmem_address !== 32'h200) begin miscompares++; $display("FAIL sb_addr: got %h want 00000200", dmem_address); end
        @(negedge clk);
        dmem_resp = 1'b0;
    endtask

    task automatic test_lb_wait;
        issue(mk(OpLoad, Lb, 32'h101, 32'h0));
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (stall_out !== 1'b1 || dmem_read !== 1'b1) begin miscompares++; $display("FAIL lb_stall%0d: got stall=%b read=%b want 1 1", i, stall_out, dmem_read); end
            @(negedge clk);
        end
        dmem_rdata = 32'h000080FF;
        dmem_resp  = 1'b1;
        #1;
        vectors++; if (stall_out !== 1'b0) begin miscompares++; $display("FAIL lb_resp_stall: got %b want 0", stall_out); end
        vectors++; if (dmem_mbe !== 4'b1111) begin miscompares++; $display("FAIL lb_mbe: got %b want 1111", dmem_mbe); end
        vectors++; if (packet_out.data.mem_rdata !== 32'hFFFFFF80) begin miscompares++; $display("FAIL lb_rdata: got %h want ffffff80", packet_out.data.mem_rdata); end
        @(negedge clk);
        dmem_resp = 1'b0;
        #1;
        vectors++; if (dmem_read !== 1'b0) begin miscompares++; $display("FAIL lb_retired: got %b want 0", dmem_read); end
    endtask

    task automatic test_lhu_done;
        issue(mk(OpLoad, Lhu, 32'h102, 32'h0));
        dmem_rdata = 32'hBEEF1234;
        dmem_resp  = 1'b1;
        stall_in   = 1'b1;
        #1;
        vectors++; if (packet_out.data.mem_rdata !== 32'h0000BEEF) begin miscompares++; $display("FAIL lhu_direct: got %h want 0000beef", packet_out.data.mem_rdata); end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            // Garbage on the port, plus a stray response in the second DONE cycle.
            dmem_rdata = (i == 0) ? 32'hFFFFFFFF : 32'h11111111;
            dmem_resp  = (i == 1);
            #1;
            vectors++; if (dmem_read !== 1'b0 || stall_out !== 1'b0) begin miscompares++; $display("FAIL lhu_done_req%0d: got read=%b stall=%b want 0 0", i, dmem_read, stall_out); end
            vectors++; if (packet_out.data.mem_rdata !== 32'h0000BEEF) begin miscompares++; $display("FAIL lhu_done_data%0d: got %h want 0000beef", i, packet_out.data.mem_rdata); end
            vectors++; if (packet_out.ctrl.valid !== 1'b1 || from_exmem !== 32'h102) begin miscompares++; $display("FAIL lhu_done_hold%0d: got valid=%b fwd=%h want 1 00000102", i, packet_out.ctrl.valid, from_exmem); end
            @(negedge clk);
        end
        dmem_resp = 1'b0;
        stall_in  = 1'b0;
        #1;
        vectors++; if (packet_out.data.mem_rdata !== 32'h0000BEEF) begin miscompares++; $display("FAIL lhu_last: got %h want 0000beef", packet_out.data.mem_rdata); end
        @(negedge clk);
        vectors++; if (packet_out.ctrl.valid !== 1'b0) begin miscompares++; $display("FAIL lhu_retired: got %b want 0", packet_out.ctrl.valid); end
    endtask

    task automatic test_reset_mid_access;
        issue(mk(OpLoad, Lw, 32'h300, 32'h0));
        @(negedge clk);
        vectors++; if (stall_out !== 1'b1) begin miscompares++; $display("FAIL rstmid_wait: got %b want 1", stall_out); end
        #1 rst = 1'b0;
        #1;
        vectors++; if (dmem_read !== 1'b0 || stall_out !== 1'b0 || dmem_mbe !== 4'b0000) begin miscompares++; $display("FAIL rstmid_outs: got read=%b stall=%b mbe=%b want 0 0 0000", dmem_read, stall_out, dmem_mbe); end
        vectors++; if (from_exmem !== 32'h0 || packet_out !== '0) begin miscompares++; $display("FAIL rstmid_regs: got fwd=%h pkt=%h want 0 0", from_exmem, packet_out); end
        @(negedge clk);
        rst = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        dmem_resp  = 1'b1;
        #1;
        vectors++; if (dmem_read !== 1'b0 || stall_out !== 1'b0) begin miscompares++; $display("FAIL rstmid_late_resp: got read=%b stall=%b want 0 0", dmem_read, stall_out); end
        @(negedge clk);
        dmem_resp = 1'b0;
        #1;
        vectors++; if (packet_out !== '0) begin miscompares++; $display("FAIL rstmid_after: got %h want 0", packet_out); end
    endtask

    task automatic test_non_mem;
        issue(mk(OpReg, 3'b000, 32'h1234, 32'h0));
        dmem_rdata = 32'h87654321;
        #1;
        vectors++; if (dmem_read !== 1'b0 || dmem_write !== 1'b0 || stall_out !== 1'b0) begin miscompares++; $display("FAIL alu_req: got read=%b write=%b stall=%b want 0 0 0", dmem_read, dmem_write, stall_out); end
        vectors++; if (packet_out.data.mem_rdata !== 32'h0 || from_exmem !== 32'h1234) begin miscompares++; $display("FAIL alu_pkt: got rdata=%h fwd=%h want 0 00001234", packet_out.data.mem_rdata, from_exmem); end
        stall_in  = 1'b1;
        packet_in = mk(OpImm, 3'b000, 32'h5678, 32'h0);
        @(negedge clk);
        vectors++; if (from_exmem !== 32'h1234) begin miscompares++; $display("FAIL stall_hold: got %h want 00001234", from_exmem); end
        stall_in = 1'b0;
        @(negedge clk);
        packet_in = '0;
        vectors++; if (from_exmem !== 32'h5678) begin miscompares++; $display("FAIL stall_release: got %h want 00005678", from_exmem); end
        @(negedge clk);
    endtask

    task automatic test_misaligned_word;
        issue(mk(OpLoad, Lw, 32'h102, 32'h0));
`ifdef MEM_MISALIGN_TRAP_EN
        #1;
        vectors++; if (dmem_read !== 1'b0 || stall_out !== 1'b0) begin miscompares++; $display("FAIL mis_req: got read=%b stall=%b want 0 0", dmem_read, stall_out); end
        vectors++; if (misalign !== 1'b1 || packet_out.ctrl.valid !== 1'b0) begin miscompares++; $display("FAIL mis_flag: got misalign=%b valid=%b want 1 0", misalign, packet_out.ctrl.valid); end
        @(negedge clk);
        vectors++; if (misalign !== 1'b0) begin miscompares++; $display("FAIL mis_clear: got %b want 0", misalign); end
`else
        dmem_rdata = 32'hAABBCCDD;
        dmem_resp  = 1'b1;
        #1;
        vectors++; if (dmem_read !== 1'b1 || dmem_address !== 32'h100 || misalign !== 1'b0) begin miscompares++; $display("FAIL mis_off_req: got read=%b addr=%h misalign=%b want 1 00000100 0", dmem_read, dmem_address, misalign); end
        vectors++; if (packet_out.data.mem_rdata !== 32'h0000AABB) begin miscompares++; $display("FAIL mis_off_data: got %h want 0000aabb", packet_out.data.mem_rdata); end
        @(negedge clk);
        dmem_resp = 1'b0;
`endif
    endtask

    initial begin
        packet_in  = '0;
        stall_in   = 1'b0;
        dmem_rdata = 32'h0;
        dmem_resp  = 1'b0;
        test_reset();
        test_sw_zero_wait();
        test_sb();
        test_lb_wait();
        test_lhu_done();
        test_reset_mid_access();
        test_non_mem();
        test_misaligned_word();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
